decode_ctrl_stage: RTL and testbench
====================================

# decode_ctrl_stage

Parametrised decode-and-latch stage for the RV32I pipeline. It decodes the ID-stage instruction into control signals and registers them into the ID/EX boundary, with stall and flush handling. Optional RV32M decode, full branch-type decode and illegal-instruction flagging are selectable by parameter. A divide-occupancy counter holds the EX control word and requests an upstream stall for the configured divider latency.

## Interface
- `M_EXT`, 1: 1 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (op 0110011, fn7 0000001); 0 flags them illegal.
- `FULL_BRANCH`, 1: 1 decodes BEQ/BNE/BLT/BGE/BLTU/BGEU; 0 decodes BEQ/BNE only, other fn3 flagged illegal.
- `DIV_CYCLES`, 33: EX occupancy of a divide/remainder op in cycles, range 2..64; counter width $clog2(DIV_CYCLES).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_i` in 32: ID-stage instruction.
- `instr_valid_i` in 1: 0 means load a bubble instead of `instr_i`.
- `stall_i` in 1: hold EX register (from hazard unit).
- `flush_i` in 1: replace EX register with bubble.
- `valid_e` out 1: EX word holds a real instruction.
- `jal_e`, `jalr_e`, `load_npc_e`, `mem_to_reg_e`, `alu_src1_e` out 1 each.
- `reg_write_e` out 3: NOREGWRITE 0, LB 1, LH 2, LW 3, LBU 4, LHU 5.
- `mem_write_e` out 4: byte mask, SB 0001, SH 0011, SW 1111.
- `reg_read_e` out 2: bit1 rs1 used, bit0 rs2 used.
- `branch_type_e` out 3: NOBRANCH 0, BEQ 1, BNE 2, BLT 3, BLTU 4, BGE 5, BGEU 6.
- `alu_ctrl_e` out 5: SLL 0, SRL 1, SRA 2, ADD 3, SUB 4, XOR 5, OR 6, AND 7, SLT 8, SLTU 9, LUI 10, MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23.
- `alu_src2_e` out 2: 00 rs2, 01 shamt, 10 immediate.
- `imm_type_e` out 3: R 0, I 1, S 2, B 3, U 4, J 5.
- `illegal_e` out 1: EX instruction is illegal.
- `md_start_e` out 1: first EX cycle of a divide/remainder op.
- `md_busy_o` out 1: divider occupying EX; combinational from counter, hazard unit stalls IF/ID on it.

Encodings live in Parameters.v; values above are binding.

## Operation
- Decode is combinational from `instr_i`; all `_e` outputs are registers.
- Decode rules: load_npc = jal|jalr. mem_to_reg on op 0000011. alu_src1=1 only for AUIPC. alu_src2=01 for SLLI/SRLI/SRAI, 00 for op 0110011 and branches, else 10. reg_read from imm type: R/S/B 11, I 10, U/J 00. Loads, stores, AUIPC, JAL, JALR and branches use ADD; LUI uses LUI.
- Illegal conditions: unknown opcode; load fn3 011/110/111; store fn3 >= 011; JALR fn3 != 000; R-type fn7 not 0000000/0100000 (or 0000001 with M_EXT); fn7 0100000 with fn3 other than 000/101; shift-imm fn7 other than 0000000, or 0100000 for fn3=101; branch per FULL_BRANCH.
- Illegal word latches as a bubble (reg_write 0, mem_write 0000, branch 0, jal/jalr 0) with illegal_e=1 and valid_e=1.
- Bubble: all outputs 0 except alu_ctrl_e=ADD(3) and imm_type_e=I(1). Same values apply at reset.
- EX register update priority: `rst` > `flush_i` (bubble) > hold (`stall_i` | `md_busy_o`) > load (decoded word, or bubble if `!instr_valid_i`).
- Divide counter `cnt` loads DIV_CYCLES-1 when a valid DIV/DIVU/REM/REMU is loaded into EX.
  - Decrements by 1 while nonzero. `md_busy_o` = (cnt != 0).
  - `rst` or `flush_i` clears cnt to 0.
- MUL family: single EX cycle, no counter.

## Timing
- Latency: instruction at `instr_i` in cycle t appears on `_e` outputs in cycle t+1.
- A divide loaded at edge t is held in EX for exactly DIV_CYCLES cycles. `md_busy_o` is high for the first DIV_CYCLES-1 of them; the next instruction loads at the following edge.
- `md_start_e` is high only in the first of those cycles and never re-asserts during a hold.
- `stall_i` asserted while cnt > 0: cnt keeps decrementing; EX is held until both are low.
- `flush_i` and `stall_i` in the same cycle: flush wins.
- `flush_i` mid-divide: bubble next cycle, `md_busy_o` low next cycle.
- Reset mid-divide: same result as flush. Every output is at its bubble value in the cycle after `rst` is sampled.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) -> next cycle valid_e=1, reg_write_e=3, alu_ctrl_e=3, alu_src2_e=10, imm_type_e=1, reg_read_e=10.
- `sub` 0x402081B3 then `srai` 0x4030D093 -> alu_ctrl_e 4 then 2; alu_src2_e 00 then 01.
- `blt` 0x0020C463: with FULL_BRANCH=1 -> branch_type_e=3, reg_write_e=0. With FULL_BRANCH=0 -> illegal_e=1, branch_type_e=0.
- `div` 0x0220C1B3 with DIV_CYCLES=4, instr_i changed every cycle:
  - alu_ctrl_e=20 held 4 cycles; md_start_e high in cycle 1 only; md_busy_o high cycles 1-3.
  - The next instruction appears in cycle 5.
  - With M_EXT=0 -> illegal_e=1 and no busy.
- `div` in EX with `flush_i` at cycle 2 -> cycle 3 bubble (valid_e=0, md_busy_o=0); `stall_i`+`flush_i` together -> bubble.
- 0xFFFFFFFF and `sw` 0x0020A023:
  - 0xFFFFFFFF -> illegal_e=1, mem_write_e=0000.
  - `sw` -> mem_write_e=1111, imm_type_e=2, reg_read_e=11.
  - `sw` with `instr_valid_i`=0 -> bubble.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: RV32I(+M) instruction decode feeding the ID/EX control
// register. It decodes the instruction combinationally and registers the
// result into the EX word, with flush, stall and bubble handling. A divide
// occupancy counter holds the EX word while the iterative divider runs.
module decode_ctrl_stage #(
  parameter int M_EXT       = 1,
  parameter int FULL_BRANCH = 1,
  parameter int DIV_CYCLES  = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        valid_e,
  output logic        jal_e,
  output logic        jalr_e,
  output logic        load_npc_e,
  output logic        mem_to_reg_e,
  output logic        alu_src1_e,
  output logic [2:0]  reg_write_e,
  output logic [3:0]  mem_write_e,
  output logic [1:0]  reg_read_e,
  output logic [2:0]  branch_type_e,
  output logic [4:0]  alu_ctrl_e,
  output logic [1:0]  alu_src2_e,
  output logic [2:0]  imm_type_e,
  output logic        illegal_e,
  output logic        md_start_e,
  output logic        md_busy_o
);

  // Counter is sized so DIV_CYCLES-1 always fits.
  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Register write / load type
  localparam logic [2:0] RW_NONE = 3'd0;
  localparam logic [2:0] RW_LB   = 3'd1;
  localparam logic [2:0] RW_LH   = 3'd2;
  localparam logic [2:0] RW_LW   = 3'd3;
  localparam logic [2:0] RW_LBU  = 3'd4;
  localparam logic [2:0] RW_LHU  = 3'd5;

  // Branch types
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BLTU = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  // ALU operations (M-extension ops are 16 + fn3)
  localparam logic [4:0] ALU_SLL  = 5'd0;
  localparam logic [4:0] ALU_SRL  = 5'd1;
  localparam logic [4:0] ALU_SRA  = 5'd2;
  localparam logic [4:0] ALU_ADD  = 5'd3;
  localparam logic [4:0] ALU_SUB  = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_AND  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_LUI  = 5'd10;

  // Second ALU operand select
  localparam logic [1:0] SRC2_RS2   = 2'b00;
  localparam logic [1:0] SRC2_SHAMT = 2'b01;
  localparam logic [1:0] SRC2_IMM   = 2'b10;

  // Immediate formats
  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  typedef struct packed {
    logic       valid;
    logic       jal;
    logic       jalr;
    logic       load_npc;
    logic       mem_to_reg;
    logic       alu_src1;
    logic [2:0] reg_write;
    logic [3:0] mem_write;
    logic [1:0] reg_read;
    logic [2:0] branch_type;
    logic [4:0] alu_ctrl;
    logic [1:0] alu_src2;
    logic [2:0] imm_type;
    logic       illegal;
  } ctrl_t;

  // The bubble is a harmless ADD with I-format immediate and no side effects.
  function automatic ctrl_t bubble_word();
    ctrl_t w;
    w          = '0;
    w.alu_ctrl = ALU_ADD;
    w.imm_type = IMM_I;
    return w;
  endfunction

  logic [6:0] opcode;
  logic [2:0] fn3;
  logic [6:0] fn7;
  assign opcode = instr_i[6:0];
  assign fn3    = instr_i[14:12];
  assign fn7    = instr_i[31:25];

  // Register specifiers and immediates are consumed downstream, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

  // Store byte mask: lane gi is written when it lies within the 2^fn3 byte access.
  logic [3:0] store_mask;
  for (genvar gi = 0; gi < 4; gi++) begin : g_store_mask
    assign store_mask[gi] = (32'(gi) < (32'd1 << fn3[1:0]));
  end

  ctrl_t dec_word;
  logic  dec_is_div;
  logic  dec_bad;

  // Combinational decode of the ID-stage instruction; illegal words collapse to a flagged bubble.
  always_comb begin
    dec_word       = bubble_word();
    dec_word.valid = 1'b1;
    dec_is_div     = 1'b0;
    dec_bad        = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_word.imm_type  = IMM_U;
        dec_word.alu_ctrl  = ALU_LUI;
        dec_word.reg_write = RW_LW;
        dec_word.alu_src2  = SRC2_IMM;
      end
      OPC_AUIPC: begin
        dec_word.imm_type  = IMM_U;
        dec_word.alu_src1  = 1'b1;
        dec_word.reg_write = RW_LW;
        dec_word.alu_src2  = SRC2_IMM;
      end
      OPC_JAL: begin
        dec_word.imm_type  = IMM_J;
        dec_word.jal       = 1'b1;
        dec_word.load_npc  = 1'b1;
        dec_word.reg_write = RW_LW;
        dec_word.alu_src2  = SRC2_IMM;
      end
      OPC_JALR: begin
        dec_word.imm_type  = IMM_I;
        dec_word.jalr      = 1'b1;
        dec_word.load_npc  = 1'b1;
        dec_word.reg_write = RW_LW;
        dec_word.alu_src2  = SRC2_IMM;
        if (fn3 != 3'b000) begin
          dec_bad = 1'b1;
        end
      end
      OPC_BRANCH: begin
        dec_word.imm_type = IMM_B;
        dec_word.alu_src2 = SRC2_RS2;
        case (fn3)
          3'b000:  dec_word.branch_type = BR_BEQ;
          3'b001:  dec_word.branch_type = BR_BNE;
          3'b100:  dec_word.branch_type = BR_BLT;
          3'b101:  dec_word.branch_type = BR_BGE;
          3'b110:  dec_word.branch_type = BR_BLTU;
          3'b111:  dec_word.branch_type = BR_BGEU;
          default: dec_bad = 1'b1;
        endcase
        // Reduced branch unit only compares for equality.
        if (FULL_BRANCH == 0 && fn3[2]) begin
          dec_bad = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec_word.imm_type   = IMM_I;
        dec_word.mem_to_reg = 1'b1;
        dec_word.alu_src2   = SRC2_IMM;
        case (fn3)
          3'b000:  dec_word.reg_write = RW_LB;
          3'b001:  dec_word.reg_write = RW_LH;
          3'b010:  dec_word.reg_write = RW_LW;
          3'b100:  dec_word.reg_write = RW_LBU;
          3'b101:  dec_word.reg_write = RW_LHU;
          default: dec_bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec_word.imm_type  = IMM_S;
        dec_word.alu_src2  = SRC2_IMM;
        dec_word.mem_write = store_mask;
        if (fn3 > 3'b010) begin
          dec_bad = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_word.imm_type  = IMM_I;
        dec_word.reg_write = RW_LW;
        dec_word.alu_src2  = SRC2_IMM;
        case (fn3)
          3'b000: dec_word.alu_ctrl = ALU_ADD;
          3'b010: dec_word.alu_ctrl = ALU_SLT;
          3'b011: dec_word.alu_ctrl = ALU_SLTU;
          3'b100: dec_word.alu_ctrl = ALU_XOR;
          3'b110: dec_word.alu_ctrl = ALU_OR;
          3'b111: dec_word.alu_ctrl = ALU_AND;
          3'b001: begin
            dec_word.alu_ctrl = ALU_SLL;
            dec_word.alu_src2 = SRC2_SHAMT;
            if (fn7 != 7'b0000000) begin
              dec_bad = 1'b1;
            end
          end
          default: begin
            dec_word.alu_src2 = SRC2_SHAMT;
            if (fn7 == 7'b0000000) begin
              dec_word.alu_ctrl = ALU_SRL;
            end else if (fn7 == 7'b0100000) begin
              dec_word.alu_ctrl = ALU_SRA;
            end else begin
              dec_bad = 1'b1;
            end
          end
        endcase
      end
      OPC_OP: begin
        dec_word.imm_type  = IMM_R;
        dec_word.reg_write = RW_LW;
        dec_word.alu_src2  = SRC2_RS2;
        case (fn7)
          7'b0000000: begin
            case (fn3)
              3'b000:  dec_word.alu_ctrl = ALU_ADD;
              3'b001:  dec_word.alu_ctrl = ALU_SLL;
              3'b010:  dec_word.alu_ctrl = ALU_SLT;
              3'b011:  dec_word.alu_ctrl = ALU_SLTU;
              3'b100:  dec_word.alu_ctrl = ALU_XOR;
              3'b101:  dec_word.alu_ctrl = ALU_SRL;
              3'b110:  dec_word.alu_ctrl = ALU_OR;
              default: dec_word.alu_ctrl = ALU_AND;
            endcase
          end
          7'b0100000: begin
            case (fn3)
              3'b000:  dec_word.alu_ctrl = ALU_SUB;
              3'b101:  dec_word.alu_ctrl = ALU_SRA;
              default: dec_bad = 1'b1;
            endcase
          end
          7'b0000001: begin
            if (M_EXT != 0) begin
              // MUL..REMU map to 16..23; fn3[2] selects the divider family.
              dec_word.alu_ctrl = {2'b10, fn3};
              dec_is_div        = fn3[2];
            end else begin
              dec_bad = 1'b1;
            end
          end
          default: dec_bad = 1'b1;
        endcase
      end
      default: dec_bad = 1'b1;
    endcase

    case (dec_word.imm_type)
      IMM_R, IMM_S, IMM_B: dec_word.reg_read = 2'b11;
      IMM_I:               dec_word.reg_read = 2'b10;
      default:             dec_word.reg_read = 2'b00;
    endcase

    if (dec_bad) begin
      dec_word         = bubble_word();
      dec_word.valid   = 1'b1;
      dec_word.illegal = 1'b1;
      dec_is_div       = 1'b0;
    end
  end

  ctrl_t            ex_reg;
  ctrl_t            ex_next;
  logic             md_start_reg;
  logic             md_start_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             hold;

  assign md_busy_o = (cnt_reg != '0);
  assign hold      = stall_i | md_busy_o;

  // Next EX word and divider count: flush beats hold, hold beats load; the counter runs through stalls.
  always_comb begin
    ex_next       = ex_reg;
    md_start_next = 1'b0;
    cnt_next      = cnt_reg;
    if (flush_i) begin
      ex_next  = bubble_word();
      cnt_next = '0;
    end else begin
      if (md_busy_o) begin
        cnt_next = cnt_reg - 1'b1;
      end
      if (!hold) begin
        if (instr_valid_i) begin
          ex_next       = dec_word;
          md_start_next = dec_is_div;
          if (dec_is_div) begin
            cnt_next = CNT_LOAD;
          end
        end else begin
          ex_next = bubble_word();
        end
      end
    end
  end

  // ID/EX register state with synchronous reset to the bubble word.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg       <= bubble_word();
      md_start_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      ex_reg       <= ex_next;
      md_start_reg <= md_start_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign valid_e       = ex_reg.valid;
  assign jal_e         = ex_reg.jal;
  assign jalr_e        = ex_reg.jalr;
  assign load_npc_e    = ex_reg.load_npc;
  assign mem_to_reg_e  = ex_reg.mem_to_reg;
  assign alu_src1_e    = ex_reg.alu_src1;
  assign reg_write_e   = ex_reg.reg_write;
  assign mem_write_e   = ex_reg.mem_write;
  assign reg_read_e    = ex_reg.reg_read;
  assign branch_type_e = ex_reg.branch_type;
  assign alu_ctrl_e    = ex_reg.alu_ctrl;
  assign alu_src2_e    = ex_reg.alu_src2;
  assign imm_type_e    = ex_reg.imm_type;
  assign illegal_e     = ex_reg.illegal;
  assign md_start_e    = md_start_reg;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: drives two decode stages (full config and reduced
// config: no M extension, BEQ/BNE only) with the same directed vectors.
// A mnemonic-level reference model predicts every output each cycle; a set
// of hand-computed literals pins the key scenarios.
module tb_decode_ctrl_stage;

  localparam int DIVC = 4;

  typedef struct packed {
    logic       valid;
    logic       jal;
    logic       jalr;
    logic       load_npc;
    logic       mem_to_reg;
    logic       alu_src1;
    logic [2:0] reg_write;
    logic [3:0] mem_write;
    logic [1:0] reg_read;
    logic [2:0] branch_type;
    logic [4:0] alu_ctrl;
    logic [1:0] alu_src2;
    logic [2:0] imm_type;
    logic       illegal;
    logic       md_start;
    logic       md_busy;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        stall_i;
  logic        flush_i;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  obs_t obs [2];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Instance 0: M_EXT=1, FULL_BRANCH=1. Instance 1: M_EXT=0, FULL_BRANCH=0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic       valid_e, jal_e, jalr_e, load_npc_e, mem_to_reg_e, alu_src1_e;
    logic [2:0] reg_write_e, branch_type_e, imm_type_e;
    logic [3:0] mem_write_e;
    logic [1:0] reg_read_e, alu_src2_e;
    logic [4:0] alu_ctrl_e;
    logic       illegal_e, md_start_e, md_busy_o;

    decode_ctrl_stage #(
      .M_EXT      ((gi == 0) ? 1 : 0),
      .FULL_BRANCH((gi == 0) ? 1 : 0),
      .DIV_CYCLES (DIVC)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_i      (instr_i),
      .instr_valid_i(instr_valid_i),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .valid_e      (valid_e),
      .jal_e        (jal_e),
      .jalr_e       (jalr_e),
      .load_npc_e   (load_npc_e),
      .mem_to_reg_e (mem_to_reg_e),
      .alu_src1_e   (alu_src1_e),
      .reg_write_e  (reg_write_e),
      .mem_write_e  (mem_write_e),
      .reg_read_e   (reg_read_e),
      .branch_type_e(branch_type_e),
      .alu_ctrl_e   (alu_ctrl_e),
      .alu_src2_e   (alu_src2_e),
      .imm_type_e   (imm_type_e),
      .illegal_e    (illegal_e),
      .md_start_e   (md_start_e),
      .md_busy_o    (md_busy_o)
    );

    assign obs[gi] = {valid_e, jal_e, jalr_e, load_npc_e, mem_to_reg_e, alu_src1_e,
                      reg_write_e, mem_write_e, reg_read_e, branch_type_e, alu_ctrl_e,
                      alu_src2_e, imm_type_e, illegal_e, md_start_e, md_busy_o};
  end

  // ---------------- reference model ----------------
  function automatic obs_t bubble_obs();
    obs_t w;
    w          = '0;
    w.alu_ctrl = 5'd3;
    w.imm_type = 3'd1;
    return w;
  endfunction

  // Decode by mnemonic class; md_start marks a legal divide/remainder.
  function automatic obs_t model_decode(logic [31:0] ins, bit mext, bit fullbr);
    obs_t w;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    w = bubble_obs();
    w.valid = 1'b1;
    ok = 1'b1;
    case (op)
      7'h37: begin w.imm_type = 4; w.alu_ctrl = 10; w.reg_write = 3; w.alu_src2 = 2; end
      7'h17: begin w.imm_type = 4; w.alu_src1 = 1; w.reg_write = 3; w.alu_src2 = 2; end
      7'h6F: begin w.imm_type = 5; w.jal = 1; w.load_npc = 1; w.reg_write = 3; w.alu_src2 = 2; end
      7'h67: begin
        w.imm_type = 1; w.jalr = 1; w.load_npc = 1; w.reg_write = 3; w.alu_src2 = 2;
        ok = (f3 == 0);
      end
      7'h63: begin
        w.imm_type = 3; w.alu_src2 = 0;
        case (f3)
          0: w.branch_type = 1;
          1: w.branch_type = 2;
          4: w.branch_type = 3;
          5: w.branch_type = 5;
          6: w.branch_type = 4;
          7: w.branch_type = 6;
          default: ok = 0;
        endcase
        if (!fullbr && f3 > 1) ok = 0;
      end
      7'h03: begin
        w.imm_type = 1; w.mem_to_reg = 1; w.alu_src2 = 2;
        case (f3)
          0: w.reg_write = 1;
          1: w.reg_write = 2;
          2: w.reg_write = 3;
          4: w.reg_write = 4;
          5: w.reg_write = 5;
          default: ok = 0;
        endcase
      end
      7'h23: begin
        w.imm_type = 2; w.alu_src2 = 2;
        case (f3)
          0: w.mem_write = 4'b0001;
          1: w.mem_write = 4'b0011;
          2: w.mem_write = 4'b1111;
          default: ok = 0;
        endcase
      end
      7'h13: begin
        w.imm_type = 1; w.reg_write = 3; w.alu_src2 = 2;
        case (f3)
          0: w.alu_ctrl = 3;
          2: w.alu_ctrl = 8;
          3: w.alu_ctrl = 9;
          4: w.alu_ctrl = 5;
          6: w.alu_ctrl = 6;
          7: w.alu_ctrl = 7;
          1: begin w.alu_ctrl = 0; w.alu_src2 = 1; ok = (f7 == 0); end
          default: begin
            w.alu_src2 = 1;
            if (f7 == 7'h00) w.alu_ctrl = 1;
            else if (f7 == 7'h20) w.alu_ctrl = 2;
            else ok = 0;
          end
        endcase
      end
      7'h33: begin
        w.imm_type = 0; w.reg_write = 3; w.alu_src2 = 0;
        if (f7 == 7'h00) begin
          case (f3)
            0: w.alu_ctrl = 3;
            1: w.alu_ctrl = 0;
            2: w.alu_ctrl = 8;
            3: w.alu_ctrl = 9;
            4: w.alu_ctrl = 5;
            5: w.alu_ctrl = 1;
            6: w.alu_ctrl = 6;
            default: w.alu_ctrl = 7;
          endcase
        end else if (f7 == 7'h20 && f3 == 0) begin
          w.alu_ctrl = 4;
        end else if (f7 == 7'h20 && f3 == 5) begin
          w.alu_ctrl = 2;
        end else if (f7 == 7'h01 && mext) begin
          w.alu_ctrl = 5'(16 + int'(f3));
          w.md_start = (f3 >= 4);
        end else begin
          ok = 0;
        end
      end
      default: ok = 0;
    endcase
    if (w.imm_type == 0 || w.imm_type == 2 || w.imm_type == 3) w.reg_read = 2'b11;
    else if (w.imm_type == 1) w.reg_read = 2'b10;
    else w.reg_read = 2'b00;
    if (!ok) begin
      w = bubble_obs();
      w.valid = 1'b1;
      w.illegal = 1'b1;
    end
    return w;
  endfunction

  // Model state: EX word, whether it is a divide, and edges elapsed since it loaded.
  obs_t mw    [2];
  bit   mdiv  [2];
  int   mage  [2];
  bit   model_live = 1'b0;

  function automatic bit model_busy(int k);
    return mdiv[k] && (mage[k] < DIVC - 1);
  endfunction

  // Model advance at each rising edge from the same inputs the DUTs sample.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || flush_i) begin
        mw[k]   <= bubble_obs();
        mdiv[k] <= 1'b0;
        mage[k] <= 0;
      end else if (stall_i || model_busy(k)) begin
        mw[k].md_start <= 1'b0;
        if (mage[k] < 1000) mage[k] <= mage[k] + 1;
      end else if (instr_valid_i) begin
        mw[k]   <= model_decode(instr_i, k == 0, k == 0);
        mdiv[k] <= model_decode(instr_i, k == 0, k == 0).md_start;
        mage[k] <= 0;
      end else begin
        mw[k]   <= bubble_obs();
        mdiv[k] <= 1'b0;
        mage[k] <= 0;
      end
    end
    if (rst) model_live <= 1'b1;
  end

  function automatic obs_t expected_word(int k);
    obs_t e;
    e = mw[k];
    e.md_busy = model_busy(k);
    return e;
  endfunction

  // Every-cycle comparison of both DUTs against the model, on the falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      for (int k = 0; k < 2; k++) begin
        checks = checks + 1;
        if (obs[k] !== expected_word(k)) begin
          failures = failures + 1;
          $display("FAIL model_cmp cycle=%0d dut=%0d actual=%h required=%h",
                   cycle, k, obs[k], expected_word(k));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int actual, input int required);
    checks = checks + 1;
    if (actual != required) begin
      failures = failures + 1;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cycle, actual, required);
    end
  endtask

  // Apply one input vector, let it be sampled, return 1 time unit after the edge.
  task automatic cyc(input logic [31:0] ins, input bit v, input bit st, input bit fl, input bit r);
    instr_i       = ins;
    instr_valid_i = v;
    stall_i       = st;
    flush_i       = fl;
    rst           = r;
    @(posedge clk);
    #1;
    $display("txn cycle=%0d instr=%h v=%0d stall=%0d flush=%0d rst=%0d | A alu=%0d ill=%0d busy=%0d | B alu=%0d ill=%0d busy=%0d",
             cycle, ins, v, st, fl, r, obs[0].alu_ctrl, obs[0].illegal, obs[0].md_busy,
             obs[1].alu_ctrl, obs[1].illegal, obs[1].md_busy);
  endtask

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] SRAI = 32'h4030D093;
  localparam logic [31:0] BLT  = 32'h0020C463;
  localparam logic [31:0] DIV  = 32'h0220C1B3;
  localparam logic [31:0] SW   = 32'h0020A023;
  localparam logic [31:0] MUL  = 32'h022081B3;

  logic [31:0] table_vec [24] = '{
    32'h123450B7, 32'h00001117, 32'h008000EF, 32'h000100E7, 32'h000110E7,
    32'h00008183, 32'h0000D183, 32'h0000B183, 32'h00208023, 32'h00209023,
    32'h0020B023, 32'h0020F463, 32'h00209463, 32'h022081B3, 32'h0220F1B3,
    32'h40309093, 32'h0030D093, 32'h0050B093, 32'h402091B3, 32'h042081B3,
    32'h0000000F, 32'h0020F1B3, 32'h0020B1B3, 32'h00208463
  };

  initial begin
    instr_i = '0; instr_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; rst = 1'b1;

    cyc(ADDI, 1, 0, 0, 1);
    cyc(ADDI, 1, 0, 0, 1);
    chk("reset_valid", obs[0].valid, 0);
    chk("reset_alu", obs[0].alu_ctrl, 3);
    chk("reset_imm", obs[0].imm_type, 1);

    cyc(ADDI, 1, 0, 0, 0);
    chk("addi_valid", obs[0].valid, 1);
    chk("addi_rw", obs[0].reg_write, 3);
    chk("addi_alu", obs[0].alu_ctrl, 3);
    chk("addi_src2", obs[0].alu_src2, 2);
    chk("addi_imm", obs[0].imm_type, 1);
    chk("addi_rr", obs[0].reg_read, 2);

    cyc(SUB, 1, 0, 0, 0);
    chk("sub_alu", obs[0].alu_ctrl, 4);
    chk("sub_src2", obs[0].alu_src2, 0);
    cyc(SRAI, 1, 0, 0, 0);
    chk("srai_alu", obs[0].alu_ctrl, 2);
    chk("srai_src2", obs[0].alu_src2, 1);

    cyc(BLT, 1, 0, 0, 0);
    chk("blt_full_br", obs[0].branch_type, 3);
    chk("blt_full_rw", obs[0].reg_write, 0);
    chk("blt_red_ill", obs[1].illegal, 1);
    chk("blt_red_br", obs[1].branch_type, 0);

    // Divide with a new instruction presented every cycle.
    cyc(DIV, 1, 0, 0, 0);
    chk("div_c1_alu", obs[0].alu_ctrl, 20);
    chk("div_c1_start", obs[0].md_start, 1);
    chk("div_c1_busy", obs[0].md_busy, 1);
    chk("div_nom_ill", obs[1].illegal, 1);
    chk("div_nom_busy", obs[1].md_busy, 0);
    cyc(ADDI, 1, 0, 0, 0);
    chk("div_c2_alu", obs[0].alu_ctrl, 20);
    chk("div_c2_start", obs[0].md_start, 0);
    chk("div_c2_busy", obs[0].md_busy, 1);
    cyc(SUB, 1, 0, 0, 0);
    chk("div_c3_busy", obs[0].md_busy, 1);
    cyc(SRAI, 1, 0, 0, 0);
    chk("div_c4_alu", obs[0].alu_ctrl, 20);
    chk("div_c4_busy", obs[0].md_busy, 0);
    cyc(SW, 1, 0, 0, 0);
    chk("div_c5_next_mw", obs[0].mem_write, 15);
    chk("sw_imm", obs[0].imm_type, 2);
    chk("sw_rr", obs[0].reg_read, 3);

    // Flush in the second divide cycle.
    cyc(DIV, 1, 0, 0, 0);
    cyc(ADDI, 1, 0, 0, 0);
    cyc(ADDI, 1, 0, 1, 0);
    chk("flush_valid", obs[0].valid, 0);
    chk("flush_busy", obs[0].md_busy, 0);

    // Stall and flush together.
    cyc(DIV, 1, 0, 0, 0);
    cyc(ADDI, 1, 1, 1, 0);
    chk("stflush_valid", obs[0].valid, 0);
    chk("stflush_busy", obs[0].md_busy, 0);

    // Reset mid-divide.
    cyc(DIV, 1, 0, 0, 0);
    cyc(ADDI, 1, 0, 0, 1);
    chk("rstdiv_valid", obs[0].valid, 0);
    chk("rstdiv_busy", obs[0].md_busy, 0);
    chk("rstdiv_alu", obs[0].alu_ctrl, 3);

    // Stall that outlasts the divide count.
    cyc(DIV, 1, 0, 0, 0);
    cyc(ADDI, 1, 1, 0, 0);
    cyc(ADDI, 1, 1, 0, 0);
    cyc(ADDI, 1, 1, 0, 0);
    cyc(ADDI, 1, 1, 0, 0);
    chk("stall_hold_alu", obs[0].alu_ctrl, 20);
    chk("stall_hold_start", obs[0].md_start, 0);
    chk("stall_hold_busy", obs[0].md_busy, 0);
    cyc(SUB, 1, 0, 0, 0);
    chk("stall_release_alu", obs[0].alu_ctrl, 4);

    cyc(32'hFFFFFFFF, 1, 0, 0, 0);
    chk("ones_ill", obs[0].illegal, 1);
    chk("ones_mw", obs[0].mem_write, 0);
    chk("ones_valid", obs[0].valid, 1);
    cyc(SW, 0, 0, 0, 0);
    chk("sw_novalid_valid", obs[0].valid, 0);
    chk("sw_novalid_mw", obs[0].mem_write, 0);

    cyc(MUL, 1, 0, 0, 0);
    chk("mul_alu", obs[0].alu_ctrl, 16);
    chk("mul_busy", obs[0].md_busy, 0);

    // Table sweep, checked by the model; second pass drops some valids and stalls.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 24; i++) begin
        cyc(table_vec[i], (p == 0) || (i % 5 != 3), (p == 1) && (i % 7 == 2), 1'b0, 1'b0);
      end
    end
    for (int i = 0; i < 6; i++) cyc(ADDI, 1, 0, 0, 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
